// File: rtl/alu_mdu.sv
// Execute unit: single-cycle base integer ALU plus iterative RV32M/RV64M
// multiply/divide engine, with valid/ready handshakes on both sides.
module alu_mdu #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      alu_ctrl,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [XLEN-1:0]   r_hi, r_lo, r_b, r_a, r_result;
    logic [2:0]        r_op;
    logic              r_sa, r_sb, r_zero;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept, w_is_m, w_a_sgn, w_b_sgn, w_sa, w_sb;
    logic [2:0]        w_op;
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]   w_amag, w_bmag, w_alu, w_fix, w_new, w_diff, w_q, w_rem;
    logic [XLEN:0]     w_rem_sh, w_sum;
    logic              w_ge, w_bz, w_load;
    logic [2*XLEN-1:0] w_prod, w_pfix;

    assign w_op     = alu_ctrl[2:0];
    assign w_is_m   = (alu_ctrl[4:3] == 2'b10);
    assign w_shamt  = B[SHAMT_W-1:0];
    assign w_accept = in_valid && (r_state == S_IDLE) && !flush;

    assign w_a_sgn = (w_op == 3'b001) || (w_op == 3'b010) ||
                     (w_op == 3'b100) || (w_op == 3'b110);
    assign w_b_sgn = (w_op == 3'b001) || (w_op == 3'b100) || (w_op == 3'b110);
    assign w_sa    = w_a_sgn && A[XLEN-1];
    assign w_sb    = w_b_sgn && B[XLEN-1];
    assign w_amag  = w_sa ? -A : A;
    assign w_bmag  = w_sb ? -B : B;

    always_comb begin
        w_alu = '0;
        case (alu_ctrl)
            5'b00000: w_alu = A & B;
            5'b00001: w_alu = A | B;
            5'b00010: w_alu = A + B;
            5'b00110: w_alu = A - B;
            5'b00011: w_alu = A ^ B;
            5'b00101: w_alu = A << w_shamt;
            5'b00100: w_alu = A >> w_shamt;
            5'b00111: w_alu = $unsigned($signed(A) >>> w_shamt);
            5'b01000: w_alu = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
            5'b01001: w_alu = {{(XLEN-1){1'b0}}, A < B};
            default:  w_alu = '0;
        endcase
    end

    // Restoring divide: r_hi is the partial remainder, r_lo the dividend/quotient.
    assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
    assign w_ge     = w_rem_sh >= {1'b0, r_b};
    assign w_diff   = w_rem_sh[XLEN-1:0] - r_b;
    // Shift-add multiply: r_lo holds the multiplier, r_b the multiplicand.
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

    assign w_prod = {r_hi, r_lo};
    assign w_pfix = (r_sa ^ r_sb) ? -w_prod : w_prod;
    assign w_q    = (r_sa ^ r_sb) ? -r_lo : r_lo;
    assign w_rem  = r_sa ? -r_hi : r_hi;
    assign w_bz   = (r_b == '0);

    // Signed overflow (MIN / -1) falls out of the magnitude path unchanged.
    always_comb begin
        w_fix = '0;
        if (!r_op[2])
            w_fix = (r_op[1:0] == 2'b00) ? w_pfix[XLEN-1:0] : w_pfix[2*XLEN-1:XLEN];
        else if (!r_op[1])
            w_fix = w_bz ? '1 : w_q;
        else
            w_fix = w_bz ? r_a : w_rem;
    end

    assign w_new  = (r_state == S_FIX) ? w_fix : w_alu;
    assign w_load = (w_accept && !w_is_m) || (r_state == S_FIX && !flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush)
            w_next = S_IDLE;
        else begin
            case (r_state)
                S_IDLE: if (w_accept) w_next = w_is_m ? S_CALC : S_DONE;
                S_CALC: if (r_cnt == CNT_W'(1)) w_next = S_FIX;
                S_FIX:  w_next = S_DONE;
                S_DONE: if (out_ready) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_CALC) || (r_state == S_FIX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_a      <= '0;
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_load) begin
                r_result <= w_new;
                r_zero   <= (w_new == '0);
            end
            if (w_accept && w_is_m) begin
                r_op  <= w_op;
                r_sa  <= w_sa;
                r_sb  <= w_sb;
                r_a   <= A;
                r_hi  <= '0;
                r_cnt <= CNT_W'(XLEN);
                r_lo  <= w_op[2] ? w_amag : w_bmag;
                r_b   <= w_op[2] ? w_bmag : w_amag;
            end else if (r_state == S_CALC && !flush) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_op[2]) begin
                    r_hi <= w_ge ? w_diff : w_rem_sh[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], w_ge};
                end else begin
                    r_hi <= w_sum[XLEN:1];
                    r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                end
            end
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (XLEN=32).
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [4:0]  alu_ctrl = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_mdu #(.XLEN(32), .SHAMT_W(5), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .alu_ctrl(alu_ctrl), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // Issue one op and wait (bounded) for out_valid; latency counts the accept edge as 1.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic zr, output int lat,
                          output logic held);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        alu_ctrl = op; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        held = 1'b1;
        while (!out_valid && lat < 60) begin
            held = held & busy & ~in_ready;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        zr = zero;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: ov=%b res=%h z=%b busy=%b rdy=%b want 0 0 0 0 1",
                     out_valid, result, zero, busy, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_base;
        logic [4:0]  ops [12] = '{5'b00010, 5'b00110, 5'b01000, 5'b01001, 5'b00111,
                                  5'b00000, 5'b00001, 5'b00011, 5'b00101, 5'b00100,
                                  5'b01010, 5'b11000};
        logic [31:0] va  [12] = '{32'd5, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                  32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0, 32'h00000001,
                                  32'h80000000, 32'h12345678, 32'h12345678};
        logic [31:0] vb  [12] = '{32'd7, 32'd9, 32'd1, 32'd1, 32'h24,
                                  32'h0000FF00, 32'h0000FF00, 32'h0000FF00, 32'h3F,
                                  32'h4, 32'h1, 32'h1};
        logic [31:0] exp [12] = '{32'd12, 32'd0, 32'd1, 32'd0, 32'hF8000000,
                                  32'h0000F000, 32'h0000FFF0, 32'h00000FF0, 32'h80000000,
                                  32'h08000000, 32'd0, 32'd0};
        logic [31:0] r;
        logic        z, h;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            run_op(ops[i], va[i], vb[i], r, z, lat, h);
            checks++;
            if (r !== exp[i] || z !== (exp[i] == 32'h0) || lat != 1) begin
                errors++;
                $display("FAIL base[%0d] op=%b: res=%h z=%b lat=%0d want %h %b 1",
                         i, ops[i], r, z, lat, exp[i], exp[i] == 32'h0);
            end
        end
    endtask

    task automatic test_mul;
        logic [4:0]  ops [6] = '{5'b10000, 5'b10011, 5'b10001, 5'b10010, 5'b10010, 5'b10000};
        logic [31:0] va  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'd2, 32'd3};
        logic [31:0] vb  [6] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd4};
        logic [31:0] exp [6] = '{32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h1, 32'd12};
        logic [31:0] r;
        logic        z, h;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], va[i], vb[i], r, z, lat, h);
            checks++;
            if (r !== exp[i] || z !== 1'b0 || lat != 34 || h !== 1'b1) begin
                errors++;
                $display("FAIL mul[%0d] op=%b: res=%h z=%b lat=%0d held=%b want %h 0 34 1",
                         i, ops[i], r, z, lat, h, exp[i]);
            end
        end
    endtask

    task automatic test_div;
        logic [4:0]  ops [10] = '{5'b10100, 5'b10110, 5'b10101, 5'b10111, 5'b10100,
                                  5'b10110, 5'b10100, 5'b10110, 5'b10101, 5'b10111};
        logic [31:0] va  [10] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000,
                                  32'h80000000, 32'd7, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] vb  [10] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'd0, 32'd0, 32'd7, 32'd7};
        logic [31:0] exp [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100,
                                  32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                  32'd14, 32'd2};
        logic [31:0] r;
        logic        z, h;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], va[i], vb[i], r, z, lat, h);
            checks++;
            if (r !== exp[i] || z !== (exp[i] == 32'h0) || lat != 34 || h !== 1'b1) begin
                errors++;
                $display("FAIL div[%0d] op=%b: res=%h z=%b lat=%0d held=%b want %h %b 34 1",
                         i, ops[i], r, z, lat, h, exp[i], exp[i] == 32'h0);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        logic        z, h;
        int          lat;
        out_ready = 1'b0;
        run_op(5'b10100, 32'd20, 32'd3, r, z, lat, h);
        checks++;
        if (r !== 32'd6 || lat != 34) begin
            errors++;
            $display("FAIL bp_div: res=%h lat=%0d want 00000006 34", r, lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd6 || zero !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ov=%b res=%h z=%b rdy=%b want 1 00000006 0 0",
                         i, out_valid, result, zero, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        run_op(5'b00010, 32'd1, 32'd2, r, z, lat, h);
        checks++;
        if (r !== 32'd3 || lat != 1) begin
            errors++;
            $display("FAIL b2b_add: res=%h lat=%0d want 00000003 1", r, lat);
        end
    endtask

    task automatic test_abort;
        logic [31:0] r;
        logic        z, h, seen;
        int          lat;
        alu_ctrl = 5'b10101; A = 32'd100; B = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: rdy=%b busy=%b ov=%b want 1 0 0", in_ready, busy, out_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_noresult: out_valid seen=%b want 0", seen);
        end
        alu_ctrl = 5'b00010; A = 32'd1; B = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_vs_accept: ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        alu_ctrl = 5'b10000; A = 32'd5; B = 32'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            result !== 32'h0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: rdy=%b busy=%b ov=%b res=%h z=%b want 1 0 0 0 0",
                     in_ready, busy, out_valid, result, zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(5'b10000, 32'd3, 32'd4, r, z, lat, h);
        checks++;
        if (r !== 32'd12 || z !== 1'b0 || lat != 34) begin
            errors++;
            $display("FAIL mul_after_reset: res=%h z=%b lat=%0d want 0000000c 0 34", r, z, lat);
        end
    endtask

    initial begin
        test_reset();
        test_base();
        test_mul();
        test_div();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised execute unit for the single-cycle RISC-V core's successor pipeline.
- Keeps the base integer ALU op set, adds SLTU, and adds RV32M multiply/divide/remainder.
- M ops run on an iterative engine that retires one bit per cycle.
- Operands enter and results leave through valid/ready handshakes, so the control path can stall on multi-cycle ops.

Parameters:
- XLEN, 32: operand/result width; legal values 32 or 64.
- SHAMT_W, 5: shift-amount bits taken from B[SHAMT_W-1:0]; must equal log2(XLEN).
- CNT_W, 6: iteration counter width; must be at least log2(XLEN)+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  unit can accept; equals (state==IDLE)
- A  input  XLEN  operand A
- B  input  XLEN  operand B
- alu_ctrl  input  5  operation select
- flush  input  1  synchronous abort of any op in flight
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  registered result
- zero  output  1  registered (result==0)
- busy  output  1  high in CALC or FIX

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: state=IDLE, out_valid=0, result=0, zero=0, busy=0, counter=0, all datapath registers cleared. in_ready=1 as soon as the state is IDLE.
- Reset during CALC/FIX/DONE discards the op. No result is ever presented for it.
- alu_ctrl encodings, base ops (bit4=0):
  - 00000 AND; 00001 OR; 00010 ADD; 00110 SUB; 00011 XOR
  - 00101 SLL; 00100 SRL; 00111 SRA; 01000 SLT (signed); 01001 SLTU (unsigned)
  - Any other bit4=0 code gives result 0.
- alu_ctrl encodings, M ops (bit4=1):
  - 10000 MUL (low XLEN bits); 10001 MULH (s×s); 10010 MULHSU (A signed × B unsigned); 10011 MULHU
  - 10100 DIV; 10101 DIVU; 10110 REM; 10111 REMU
  - Codes 11000-11111 execute as base op with result 0.
- Accept condition: in_valid && in_ready on a rising edge. A, B and alu_ctrl are latched at that edge. Inputs are ignored at all other times.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE, accept of base op: compute combinationally, register result and zero, go to DONE. out_valid=1 on the next cycle (latency 1).
  - IDLE, accept of M op: take operand magnitudes (signedness per op), load counter=XLEN, go to CALC.
  - CALC: one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle; decrement counter. When counter reaches 1, go to FIX after that step.
  - FIX: apply sign correction and special cases, register result and zero, go to DONE.
  - M-op latency is fixed at XLEN+2 edges after the accept edge, independent of operand values, including special cases.
  - DONE: out_valid=1. result and zero are held stable while out_ready=0. On out_valid && out_ready, go to IDLE and drop out_valid.
- in_ready is 0 in CALC, FIX and DONE. There is no accept in the same cycle as a result handoff; the next accept is possible one cycle later.
- Sign rules:
  - Quotient is negative if signs differ.
  - Remainder takes the sign of the dividend.
  - MULH/MULHSU produce the upper XLEN bits of the 2·XLEN signed product.
- Special cases, applied in FIX:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = A.
  - Signed overflow (A = most negative value, B = -1): DIV = A; REM = 0.
- Shifts use only B[SHAMT_W-1:0]. SRA replicates A[XLEN-1].
- flush=1 on a rising edge: go to IDLE and clear out_valid, from any state. flush has priority over accept and handoff. An in_valid in the same cycle as flush is not accepted.
- zero is computed from the final registered result value.

Test Plan:
- ADD A=5, B=7, out_ready=1 → out_valid one cycle after accept, result=12, zero=0. SUB A=9, B=9 → result=0, zero=1.
- SLT A=0xFFFFFFFF, B=1 → 1; SLTU with same operands → 0. SRA A=0x80000000, B=0x24 → shift 4, result 0xF8000000.
- MUL A=0xFFFFFFFF, B=2 → 0xFFFFFFFE. MULHU with same operands → 0x00000001. MULH with same operands → 0xFFFFFFFF. out_valid exactly 34 edges after accept; in_ready=0 and busy=1 meanwhile.
- DIV A=-7 (0xFFFFFFF9), B=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU A=100, B=0 → 0xFFFFFFFF; REMU → 100. DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM → 0. All complete with 34-cycle latency.
- Back-pressure: hold out_ready=0 for 5 cycles after DIV completes → result, zero and out_valid stable, in_ready=0. Raise out_ready → next cycle out_valid=0, in_ready=1. Then accept ADD back-to-back and check its result.
- Abort: start DIVU; pulse flush at cycle 10 → IDLE next edge, no out_valid. Repeat with rst_n low at cycle 20 → immediate IDLE, result=0. A following MUL 3×4 → 12.
